ps2_host_tx: RTL and testbench



---
 rtl/ps2_host_tx_pkg.sv | 24 ++
 rtl/ps2_host_tx_line_sync.sv | 34 +++
 rtl/ps2_host_tx.sv | 207 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host transmit and mouse receive paths.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SHIFT,
      ACK,
      WAIT_IDLE,
      FAIL
   } ps2_state_t;

   localparam logic [7:0] PS2_CMD_RESET       = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE      = 8'hF4;
   localparam logic [7:0] PS2_CMD_SAMPLE_RATE = 8'hF3;
   localparam logic [7:0] PS2_RESP_ACK        = 8'hFA;

   // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchronizers for the raw ps2_clk/ps2_data pins plus ps2_clk falling-edge detect.
// Shared with the mouse receive path.
module ps2_line_sync (
   input  logic clock,
   input  logic reset_n,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic sync_clk_o,
   output logic sync_data_o,
   output logic clk_fall_o
);

   logic [1:0] clk_ff_q;
   logic [1:0] data_ff_q;
   logic       clk_prev_q;

   // Flops reset to 1 (idle bus level) so leaving reset never looks like a falling edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clk_ff_q   <= 2'b11;
         data_ff_q  <= 2'b11;
         clk_prev_q <= 1'b1;
      end else begin
         clk_ff_q   <= {clk_ff_q[0], ps2_clk_i};
         data_ff_q  <= {data_ff_q[0], ps2_data_i};
         clk_prev_q <= clk_ff_q[1];
      end
   end

   assign sync_clk_o  = clk_ff_q[1];
   assign sync_data_o = data_ff_q[1];
   assign clk_fall_o  = clk_prev_q & ~clk_ff_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift out byte + odd parity, check ack.
// Optional PS2_TX_RETRY_EN: NACK/timeout restarts the frame up to MAX_RETRIES times before tx_error.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 12_000,
   parameter int SETUP_CYCLES   = 16,
   parameter int TIMEOUT_CYCLES = 1_500_000,
   parameter int MAX_RETRIES    = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_drive_low,
   output logic       ps2_data_drive_low,
   output logic       tx_done,
   output logic       tx_error,
   output logic       busy,
   output logic       rx_inhibit
);

   localparam int PH_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
   localparam logic [PH_W-1:0] REQ_LAST = PH_W'(SETUP_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   ps2_state_t      state_q;
   logic [PH_W-1:0] ph_cnt_q;
   logic [TO_W-1:0] to_cnt_q;
   logic [TO_W-1:0] to_cnt_d;
   logic [3:0]      bit_cnt_q;
   logic [8:0]      byte_q;
   logic [8:0]      shift_q;
   logic            clk_drv_q;
   logic            data_drv_q;
   logic            ready_q;
   logic            busy_q;
   logic            done_q;
   logic            error_q;

   logic sync_clk;
   logic sync_data;
   logic clk_fall;
   logic timeout_hit;
   logic fail_now;

`ifdef PS2_TX_RETRY_EN
   localparam int RT_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   logic [RT_W-1:0] retry_q;
`else
   logic unused_max_retries;
   assign unused_max_retries = (MAX_RETRIES != 0);
`endif

   ps2_line_sync u_sync (
      .clock       (clock),
      .reset_n     (reset_n),
      .ps2_clk_i   (ps2_clk_in),
      .ps2_data_i  (ps2_data_in),
      .sync_clk_o  (sync_clk),
      .sync_data_o (sync_data),
      .clk_fall_o  (clk_fall)
   );

   // Timeout counter saturates at its terminal value, which is also the timeout condition.
   always_comb begin
      timeout_hit = (to_cnt_q == TO_LAST);
      to_cnt_d    = timeout_hit ? to_cnt_q : to_cnt_q + 1'b1;
      fail_now    = ((state_q == SHIFT) || (state_q == ACK)) &&
                    (timeout_hit || ((state_q == ACK) && clk_fall && sync_data));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         ph_cnt_q   <= '0;
         to_cnt_q   <= '0;
         bit_cnt_q  <= '0;
         byte_q     <= '0;
         shift_q    <= '0;
         clk_drv_q  <= 1'b0;
         data_drv_q <= 1'b0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         retry_q    <= '0;
`endif
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         if (fail_now) begin
            clk_drv_q  <= 1'b0;
            data_drv_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retry_q < RT_W'(MAX_RETRIES)) begin
               retry_q   <= retry_q + 1'b1;
               clk_drv_q <= 1'b1;
               ph_cnt_q  <= '0;
               state_q   <= INHIBIT;
            end else begin
               state_q <= FAIL;
            end
`else
            state_q <= FAIL;
`endif
         end else begin
            case (state_q)
               IDLE: begin
                  if (tx_valid && ready_q) begin
                     byte_q     <= {odd_parity(tx_data), tx_data};
                     ready_q    <= 1'b0;
                     busy_q     <= 1'b1;
                     clk_drv_q  <= 1'b1;
                     data_drv_q <= 1'b0;
                     ph_cnt_q   <= '0;
                     state_q    <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
                     retry_q    <= '0;
`endif
                  end
               end
               INHIBIT: begin
                  if (ph_cnt_q == INH_LAST) begin
                     ph_cnt_q   <= '0;
                     data_drv_q <= 1'b1;
                     state_q    <= REQ;
                  end else begin
                     ph_cnt_q <= ph_cnt_q + 1'b1;
                  end
               end
               REQ: begin
                  if (ph_cnt_q == REQ_LAST) begin
                     clk_drv_q <= 1'b0;
                     to_cnt_q  <= '0;
                     bit_cnt_q <= '0;
                     shift_q   <= byte_q;
                     state_q   <= SHIFT;
                  end else begin
                     ph_cnt_q <= ph_cnt_q + 1'b1;
                  end
               end
               SHIFT: begin
                  to_cnt_q <= to_cnt_d;
                  if (clk_fall) begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     // Tenth falling edge: release data so the device sees the stop bit.
                     if (bit_cnt_q == 4'd9) begin
                        data_drv_q <= 1'b0;
                        state_q    <= ACK;
                     end else begin
                        data_drv_q <= ~shift_q[0];
                        shift_q    <= {1'b1, shift_q[8:1]};
                     end
                  end
               end
               ACK: begin
                  to_cnt_q <= to_cnt_d;
                  if (clk_fall) begin
                     state_q <= WAIT_IDLE;
                  end
               end
               WAIT_IDLE: begin
                  if (sync_clk && sync_data) begin
                     done_q  <= 1'b1;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
               FAIL: begin
                  error_q    <= 1'b1;
                  clk_drv_q  <= 1'b0;
                  data_drv_q <= 1'b0;
                  ready_q    <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end
               default: begin
                  clk_drv_q  <= 1'b0;
                  data_drv_q <= 1'b0;
                  ready_q    <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end
            endcase
         end
      end
   end

   assign tx_ready           = ready_q;
   assign busy               = busy_q;
   assign rx_inhibit         = busy_q;
   assign tx_done            = done_q;
   assign tx_error           = error_q;
   assign ps2_clk_drive_low  = clk_drv_q;
   assign ps2_data_drive_low = data_drv_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: table vectors, random bytes against a frame model,
// timeout, NACK/retry, mid-frame reset and held tx_valid corner cases.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH = 300;
   localparam int SET = 16;
   localparam int TO  = 2500;
   localparam int MR  = 2;
`ifdef PS2_TX_RETRY_EN
   localparam int ATTEMPTS_ON_FAIL = MR + 1;
`else
   localparam int ATTEMPTS_ON_FAIL = 1;
`endif

   typedef struct {
      logic [7:0]  data;
      bit          ack;
      bit          junk;
      logic [10:0] frame;
   } vec_t;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_ready, clk_dl, data_dl, tx_done, tx_error, busy, rx_inhibit;
   logic       dev_clk  = 1'b1;
   logic       dev_data = 1'b1;
   logic       clk_line, data_line;

   // Open-drain bus: either side pulling low wins.
   assign clk_line  = dev_clk & ~clk_dl;
   assign data_line = dev_data & ~data_dl;

   always #5 clock = ~clock;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .SETUP_CYCLES   (SET),
      .TIMEOUT_CYCLES (TO),
      .MAX_RETRIES    (MR)
   ) dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .tx_valid           (tx_valid),
      .tx_data            (tx_data),
      .tx_ready           (tx_ready),
      .ps2_clk_in         (clk_line),
      .ps2_data_in        (data_line),
      .ps2_clk_drive_low  (clk_dl),
      .ps2_data_drive_low (data_dl),
      .tx_done            (tx_done),
      .tx_error           (tx_error),
      .busy               (busy),
      .rx_inhibit         (rx_inhibit)
   );

   int total = 0;
   int bad   = 0;

   // Cumulative bus/handshake monitors; tests compare before/after snapshots.
   int   mon_inh = 0, mon_set = 0, mon_phase = 0, mon_done = 0, mon_err = 0;
   int   mon_busy_rise = 0, mon_bad = 0;
   logic prev_inh_q = 1'b0, prev_busy_q = 1'b0;

   always @(negedge clock) begin
      if (reset_n) begin
         if (clk_dl && !data_dl) mon_inh <= mon_inh + 1;
         if (clk_dl && data_dl) mon_set <= mon_set + 1;
         if (clk_dl && !data_dl && !prev_inh_q) mon_phase <= mon_phase + 1;
         if (tx_done) mon_done <= mon_done + 1;
         if (tx_error) mon_err <= mon_err + 1;
         if (busy && !prev_busy_q) mon_busy_rise <= mon_busy_rise + 1;
         if ((rx_inhibit !== busy) || (tx_ready === busy) || (tx_done && tx_error))
            mon_bad <= mon_bad + 1;
      end
      prev_inh_q  <= clk_dl && !data_dl;
      prev_busy_q <= busy;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Reference frame in bus order: start 0, data LSB first, odd parity, stop 1.
   function automatic logic [10:0] model_frame(input logic [7:0] b);
      int          ones;
      logic [10:0] f;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = b[i];
      f[9]  = ((ones % 2) == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit junk);
      @(negedge clock);
      tx_valid = 1'b1;
      tx_data  = b;
      @(negedge clock);
      check("accepted", busy, 1);
      if (junk) tx_data = 8'h55;
      else tx_valid = 1'b0;
   endtask

   task automatic wait_release(output bit ok);
      int c;
      ok = 1'b0;
      c  = 0;
      while (c < INH + SET + 100) begin
         @(negedge clock);
         if (!clk_dl && data_dl) begin
            ok = 1'b1;
            break;
         end
         c++;
      end
   endtask

   // Device model: samples data while clock is high, just before each falling edge.
   task automatic dev_clocks(input int n, input bit ack, output logic [10:0] bits);
      int hp;
      hp   = int'($urandom_range(15, 30));
      bits = '0;
      for (int k = 0; k < n; k++) begin
         repeat (hp / 2) @(negedge clock);
         bits[k] = data_line;
         if (k == 10 && ack) dev_data = 1'b0;
         repeat (hp - hp / 2) @(negedge clock);
         dev_clk = 1'b0;
         if (k == 10) tx_valid = 1'b0;
         repeat (hp) @(negedge clock);
         dev_clk = 1'b1;
      end
      repeat (hp / 2) @(negedge clock);
      dev_data = 1'b1;
   endtask

   task automatic run_frame(input logic [7:0] b, input bit ack, input bit junk,
                            input logic [10:0] exp_bits, input int id);
      int          s_inh, s_set, s_ph, s_done, s_err, s_br, s_bad, attempts, c;
      bit          ok;
      logic [10:0] bits, first_bits;
      s_inh = mon_inh; s_set = mon_set; s_ph = mon_phase; s_done = mon_done;
      s_err = mon_err; s_br = mon_busy_rise; s_bad = mon_bad;
      attempts   = ack ? 1 : ATTEMPTS_ON_FAIL;
      first_bits = '0;
      send_byte(b, junk);
      for (int a = 0; a < attempts; a++) begin
         wait_release(ok);
         check("clock release", ok, 1);
         if (!ok) break;
         dev_clocks(11, ack, bits);
         if (a == 0) first_bits = bits;
      end
      c = 0;
      while (!tx_ready && c < 500) begin
         @(negedge clock);
         c++;
      end
      repeat (3) @(negedge clock);
      check("frame bits", first_bits, exp_bits);
      check("done pulses", mon_done - s_done, ack ? 1 : 0);
      check("error pulses", mon_err - s_err, ack ? 0 : 1);
      check("inhibit cycles", mon_inh - s_inh, attempts * INH);
      check("setup cycles", mon_set - s_set, attempts * SET);
      check("inhibit phases", mon_phase - s_ph, attempts);
      check("accepts", mon_busy_rise - s_br, 1);
      check("handshake flags", mon_bad - s_bad, 0);
      check("clk released", clk_dl, 0);
      check("data released", data_dl, 0);
      check("ready after", tx_ready, 1);
      $display("frame %0d: data=0x%02h ack=%0d junk=%0d attempts=%0d bits=0x%03h",
               id, b, ack, junk, attempts, first_bits);
   endtask

   initial begin
      vec_t        tbl [5];
      logic [10:0] bits;
      logic [7:0]  rb;
      bit          ok, rack, seen;
      int          c, s_err, s_done, s_ph;

      tbl[0] = '{data: PS2_CMD_ENABLE,      ack: 1'b1, junk: 1'b0, frame: {1'b1, 1'b0, 8'hF4, 1'b0}};
      tbl[1] = '{data: PS2_CMD_RESET,       ack: 1'b1, junk: 1'b0, frame: {1'b1, 1'b1, 8'hFF, 1'b0}};
      tbl[2] = '{data: PS2_CMD_SAMPLE_RATE, ack: 1'b0, junk: 1'b0, frame: {1'b1, 1'b1, 8'hF3, 1'b0}};
      tbl[3] = '{data: PS2_CMD_ENABLE,      ack: 1'b1, junk: 1'b1, frame: {1'b1, 1'b0, 8'hF4, 1'b0}};
      tbl[4] = '{data: 8'h01,               ack: 1'b1, junk: 1'b0, frame: {1'b1, 1'b0, 8'h01, 1'b0}};

      repeat (4) @(negedge clock);
      check("reset clk drive", clk_dl, 0);
      check("reset data drive", data_dl, 0);
      check("reset tx_ready", tx_ready, 1);
      check("reset busy", busy, 0);
      check("reset rx_inhibit", rx_inhibit, 0);
      check("reset tx_done", tx_done, 0);
      check("reset tx_error", tx_error, 0);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);

      for (int i = 0; i < 5; i++)
         run_frame(tbl[i].data, tbl[i].ack, tbl[i].junk, tbl[i].frame, i);

      for (int i = 0; i < 6; i++) begin
         rb   = 8'($urandom);
         rack = ($urandom_range(0, 3) != 0);
         run_frame(rb, rack, 1'b0, model_frame(rb), 10 + i);
      end

      // Device never clocks: expect tx_error about TO cycles after the final clock release.
      s_err = mon_err; s_done = mon_done; s_ph = mon_phase;
      send_byte(PS2_CMD_RESET, 1'b0);
      for (int a = 0; a < ATTEMPTS_ON_FAIL; a++) begin
         wait_release(ok);
         check("timeout release", ok, 1);
         if (!ok) break;
         c    = 0;
         seen = 1'b0;
         while (c < TO + 50) begin
            @(negedge clock);
            c++;
            if (tx_error) begin
               seen = 1'b1;
               break;
            end
            if (clk_dl) break;
         end
         if (a == ATTEMPTS_ON_FAIL - 1) begin
            check("timeout error seen", seen, 1);
            check_range("timeout latency", c, TO - 3, TO + 3);
            check("timeout clk drive", clk_dl, 0);
            check("timeout data drive", data_dl, 0);
         end
      end
      repeat (3) @(negedge clock);
      check("timeout error pulses", mon_err - s_err, 1);
      check("timeout done pulses", mon_done - s_done, 0);
      check("timeout phases", mon_phase - s_ph, ATTEMPTS_ON_FAIL);
      $display("frame timeout: data=0x%02h latency=%0d", PS2_CMD_RESET, c);

      // Asynchronous reset in the middle of bit 4.
      send_byte(8'h00, 1'b0);
      wait_release(ok);
      check("reset-test release", ok, 1);
      dev_clocks(4, 1'b0, bits);
      @(negedge clock);
      check("data driven before reset", data_dl, 1);
      #2 reset_n = 1'b0;
      #1;
      check("async clk release", clk_dl, 0);
      check("async data release", data_dl, 0);
      check("async tx_ready", tx_ready, 1);
      check("async busy", busy, 0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      $display("frame reset: aborted at bit 4, bus released");
      run_frame(8'h00, 1'b1, 1'b0, {1'b1, 1'b1, 8'h00, 1'b0}, 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
